// File: rtl/agu_adder_arbiter_if.sv
// Request/response bundle between the AGU requesters, the shared adder arbiter and the result consumer.
// The slave modport is the arbiter side; the master modport is the requester/consumer side.
interface agu_adder_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*64-1:0] req_base;
    logic [NUM_REQ*12-1:0] req_imm;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [64:0]           rsp_sum;
    logic [ID_W-1:0]       rsp_id;
    logic                  flush;
    logic                  busy;

    modport slave (
        input  req_valid, req_base, req_imm, rsp_ready, flush,
        output req_ready, rsp_valid, rsp_sum, rsp_id, busy
    );

    modport master (
        output req_valid, req_base, req_imm, rsp_ready, flush,
        input  req_ready, rsp_valid, rsp_sum, rsp_id, busy
    );
endinterface

// File: rtl/agu_adder_arbiter.sv
// Shared 64b + 12b AGU adder with round-robin arbitration and one registered, id-tagged result stage.
// Optional AGU_ARB_PRIO_EN: requester 0 gets fixed top priority; requesters 1..NUM_REQ-1 share round-robin.
module agu_adder_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned RR_INIT = 0
) (
    input  logic               clk,
    input  logic               reset,
    agu_adder_arbiter_if.slave bus
);
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BASE_W = 64;
    localparam int unsigned IMM_W  = 12;
    localparam int unsigned SUM_W  = 65;
`ifdef AGU_ARB_PRIO_EN
    // Pointer never names requester 0 in priority mode.
    localparam int unsigned RR_RST = (RR_INIT == 0) ? 1 : RR_INIT;
`else
    localparam int unsigned RR_RST = RR_INIT;
`endif

    typedef enum logic {EMPTY, FULL} state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_found;
    logic               can_accept_c;
    logic               accept_c;
    logic [NUM_REQ-1:0] ready_c;
    logic [BASE_W-1:0]  base_sel;
    logic [IMM_W-1:0]   imm_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            rr_q    <= ID_W'(RR_RST);
            id_q    <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
        end
    end

    // Rotating priority search starting at rr_q.
    always_comb begin
        int unsigned pos;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        pos       = 0;
`ifdef AGU_ARB_PRIO_EN
        if (bus.req_valid[0]) begin
            gnt_found = 1'b1;
        end
        for (int unsigned k = 0; k < NUM_REQ - 1; k++) begin
            pos = 1 + ((32'(rr_q) - 1 + k) % (NUM_REQ - 1));
            if (!gnt_found && bus.req_valid[ID_W'(pos)]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(pos);
            end
        end
`else
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = (32'(rr_q) + k) % NUM_REQ;
            if (!gnt_found && bus.req_valid[ID_W'(pos)]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(pos);
            end
        end
`endif
    end

    assign base_sel = bus.req_base[BASE_W*32'(gnt_idx) +: BASE_W];
    assign imm_sel  = bus.req_imm[IMM_W*32'(gnt_idx) +: IMM_W];

    // Next-state: flush wins, then accept (which also covers drain-and-refill), then plain drain.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        id_d         = id_q;
        sum_d        = sum_q;
        ready_c      = '0;
        can_accept_c = !reset && !bus.flush && ((state_q == EMPTY) || bus.rsp_ready);
        accept_c     = can_accept_c && gnt_found;
        if (accept_c) begin
            ready_c[gnt_idx] = 1'b1;
        end
        if (bus.flush) begin
            state_d = EMPTY;
        end else if (accept_c) begin
            state_d = FULL;
            sum_d   = {1'b0, base_sel} + SUM_W'(imm_sel);
            id_d    = gnt_idx;
`ifdef AGU_ARB_PRIO_EN
            if (gnt_idx != '0) begin
                rr_d = (32'(gnt_idx) == NUM_REQ - 1) ? ID_W'(1) : ID_W'(32'(gnt_idx) + 1);
            end
`else
            rr_d = ID_W'((32'(gnt_idx) + 1) % NUM_REQ);
`endif
        end else if ((state_q == FULL) && bus.rsp_ready) begin
            state_d = EMPTY;
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_id    = id_q;
    assign bus.busy      = (state_q == FULL) || (|bus.req_valid);
endmodule

// File: tb/tb_agu_adder_arbiter.sv
// Scoreboard bench for agu_adder_arbiter: a reference arbiter model pushes expected sums on accept
// and they are compared when the result register is observed.
module tb_agu_adder_arbiter;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
`ifdef AGU_ARB_PRIO_EN
    localparam int unsigned RR_RST  = 1;
`else
    localparam int unsigned RR_RST  = 0;
`endif

    typedef struct packed {
        logic [64:0]     sum;
        logic [ID_W-1:0] id;
    } exp_t;

    logic clk;
    logic reset;
    agu_adder_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    agu_adder_arbiter #(.NUM_REQ(NUM_REQ), .RR_INIT(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t               sb_q[$];
    logic               m_full;
    int                 m_rr;
    logic [NUM_REQ-1:0] last_ready;
    int                 n_vec;
    int                 n_err;

    task automatic set_op(input int i, input logic [63:0] b, input logic [11:0] imm);
        bus.req_base[64*i +: 64] = b;
        bus.req_imm[12*i +: 12]  = imm;
    endtask

    function automatic int model_grant();
`ifdef AGU_ARB_PRIO_EN
        if (bus.req_valid[0]) return 0;
        for (int k = 0; k < NUM_REQ - 1; k++) begin
            int i;
            i = 1 + ((m_rr - 1 + k) % (NUM_REQ - 1));
            if (bus.req_valid[i]) return i;
        end
`else
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (m_rr + k) % NUM_REQ;
            if (bus.req_valid[i]) return i;
        end
`endif
        return -1;
    endfunction

    // One clock: inputs already driven at the falling edge; check, then advance the model across the edge.
    task automatic step();
        int                 g;
        logic [NUM_REQ-1:0] exp_ready;
        logic               exp_busy;
        exp_t               e;
        #1;
        g = -1;
        if (!reset && !bus.flush && (!m_full || bus.rsp_ready)) g = model_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        last_ready = bus.req_ready;
        n_vec++;
        if (bus.req_ready !== exp_ready) begin
            n_err++;
            $display("FAIL req_ready t=%0t: got %b expected %b", $time, bus.req_ready, exp_ready);
        end
        n_vec++;
        if (bus.rsp_valid !== m_full) begin
            n_err++;
            $display("FAIL rsp_valid t=%0t: got %b expected %b", $time, bus.rsp_valid, m_full);
        end
        exp_busy = m_full | (|bus.req_valid);
        n_vec++;
        if (bus.busy !== exp_busy) begin
            n_err++;
            $display("FAIL busy t=%0t: got %b expected %b", $time, bus.busy, exp_busy);
        end
        if (m_full && sb_q.size() > 0) begin
            e = sb_q[0];
            n_vec++;
            if (bus.rsp_sum !== e.sum || bus.rsp_id !== e.id) begin
                n_err++;
                $display("FAIL rsp_data t=%0t: got sum=%h id=%0d expected sum=%h id=%0d",
                         $time, bus.rsp_sum, bus.rsp_id, e.sum, e.id);
            end
        end
        @(posedge clk);
        if (reset) begin
            m_full = 1'b0;
            sb_q.delete();
            m_rr = RR_RST;
        end else if (bus.flush) begin
            if (m_full && sb_q.size() > 0) void'(sb_q.pop_front());
            m_full = 1'b0;
        end else begin
            if (m_full && bus.rsp_ready) begin
                if (sb_q.size() > 0) void'(sb_q.pop_front());
                m_full = 1'b0;
            end
            if (g >= 0) begin
                e.sum = {1'b0, bus.req_base[64*g +: 64]} + {53'b0, bus.req_imm[12*g +: 12]};
                e.id  = ID_W'(g);
                sb_q.push_back(e);
                m_full = 1'b1;
`ifdef AGU_ARB_PRIO_EN
                if (g != 0) m_rr = (g == NUM_REQ - 1) ? 1 : g + 1;
`else
                m_rr = (g + 1) % NUM_REQ;
`endif
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        bus.flush     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        step();
        n_vec++;
        if (bus.rsp_sum !== 65'h0 || bus.rsp_id !== '0 || last_ready !== '0) begin
            n_err++;
            $display("FAIL reset_values: got sum=%h id=%0d ready=%b expected 0/0/0",
                     bus.rsp_sum, bus.rsp_id, last_ready);
        end
        reset         = 1'b0;
        bus.req_valid = '0;
    endtask

    task automatic test_single();
        set_op(0, 64'h1000, 12'h00C);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        step();
        bus.req_valid = '0;
        n_vec++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 65'h100C || bus.rsp_id !== 2'd0) begin
            n_err++;
            $display("FAIL single: got v=%b sum=%h id=%0d expected 1/100c/0",
                     bus.rsp_valid, bus.rsp_sum, bus.rsp_id);
        end
        step();
    endtask

    task automatic test_round_robin();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 64'h100 * (i + 1), 12'(i + 1));
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
`ifndef AGU_ARB_PRIO_EN
            n_vec++;
            if (last_ready !== 4'(1 << (c % NUM_REQ))) begin
                n_err++;
                $display("FAIL rr_order cycle %0d: got %b expected %b", c, last_ready, 4'(1 << (c % NUM_REQ)));
            end
`endif
        end
        bus.req_valid = '0;
        step();
    endtask

    task automatic test_carry();
        set_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 12'hFFF);
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b1;
        step();
        bus.req_valid = '0;
        n_vec++;
        if (bus.rsp_sum !== 65'h1_0000_0000_0000_0FFE || bus.rsp_id !== 2'd2) begin
            n_err++;
            $display("FAIL carry: got sum=%h id=%0d expected 10000000000000ffe/2", bus.rsp_sum, bus.rsp_id);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [64:0] held;
        set_op(0, 64'hDEAD_0000, 12'h123);
        set_op(1, 64'h1111, 12'h1);
        set_op(2, 64'h2222, 12'h2);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b0;
        step();
        held          = bus.rsp_sum;
        bus.req_valid = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            step();
            n_vec++;
            if (last_ready !== '0 || bus.rsp_sum !== held) begin
                n_err++;
                $display("FAIL backpressure cycle %0d: got ready=%b sum=%h expected 0000/%h",
                         c, last_ready, bus.rsp_sum, held);
            end
        end
        bus.rsp_ready = 1'b1;
        step();
`ifndef AGU_ARB_PRIO_EN
        n_vec++;
        if (last_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL bp_release: got %b expected 0010", last_ready);
        end
`endif
        bus.req_valid = '0;
        step();
    endtask

    task automatic test_flush();
        set_op(0, 64'h4000, 12'h40);
        set_op(3, 64'h3333, 12'h333);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b0;
        step();
        bus.req_valid = 4'b1000;
        bus.flush     = 1'b1;
        step();
        bus.flush = 1'b0;
        n_vec++;
        if (last_ready !== '0 || bus.rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush: got ready=%b rsp_valid=%b expected 0000/0", last_ready, bus.rsp_valid);
        end
        step();
        n_vec++;
        if (last_ready !== 4'b1000) begin
            n_err++;
            $display("FAIL post_flush_grant: got %b expected 1000", last_ready);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!bus.req_valid[i] || last_ready[i]) begin
                    bus.req_valid[i] = ($urandom_range(0, 2) != 0);
                    if ($urandom_range(0, 7) == 0) set_op(i, 64'hFFFF_FFFF_FFFF_FFFF, 12'($urandom_range(0, 4095)));
                    else set_op(i, {$urandom(), $urandom()}, 12'($urandom_range(0, 4095)));
                end
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 11) == 0);
            step();
        end
        bus.req_valid = '0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        step();
        n_vec++;
        if (bus.rsp_valid !== 1'b0 || sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got rsp_valid=%b pending=%0d expected 0/0", bus.rsp_valid, sb_q.size());
        end
    endtask

`ifdef AGU_ARB_PRIO_EN
    task automatic test_prio();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 64'h5000 + 64'(i), 12'(i));
        bus.req_valid = 4'b1011;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            n_vec++;
            if (last_ready !== 4'b0001) begin
                n_err++;
                $display("FAIL prio cycle %0d: got %b expected 0001", c, last_ready);
            end
        end
        bus.req_valid = 4'b1010;
        step();
        n_vec++;
        if (last_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL prio_rr_unchanged: got %b expected 0010", last_ready);
        end
        bus.req_valid = '0;
        step();
    endtask
`endif

    initial begin
        n_vec         = 0;
        n_err         = 0;
        m_full        = 1'b0;
        m_rr          = RR_RST;
        last_ready    = '0;
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_base  = '0;
        bus.req_imm   = '0;
        bus.rsp_ready = 1'b0;
        bus.flush     = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_carry();
        test_backpressure();
        test_flush();
`ifdef AGU_ARB_PRIO_EN
        test_prio();
`endif
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
